eq_band_mixer: RTL

EQ_BAND_MIXER -- requirements
Module: eq_band_mixer

---
 rtl/eq_pkg.sv | 10 +
 rtl/eq_mac.sv | 25 ++
 rtl/eq_band_mixer.sv | 97 +++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// eq_pkg: shared FSM encoding, unity-gain constant and accumulator sizing for eq_band_mixer
package eq_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;
   function automatic int unity_gain(input int frac);
      return 1 << frac;
   endfunction
   function automatic int acc_width(input int n, input int gain_w, input int bands);
      return 2 * n + gain_w + $clog2(bands);
   endfunction
endpackage

// File: rtl/eq_mac.sv
// eq_mac: signed multiply-accumulate datapath, one product per enabled cycle
// Ports: clk, rst (async active-low), clr (zero the accumulator), en (accumulate),
//        sample (signed band sample), gain (signed gain), sum (accumulator plus current product)
module eq_mac #(
   parameter int N      = 16,
   parameter int GAIN_W = 8,
   parameter int ACC_W  = 43
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [N*2-1:0]    sample,
   input  logic signed [GAIN_W-1:0] gain,
   output logic signed [ACC_W-1:0]  sum
);
   logic signed [N*2+GAIN_W-1:0] prod;
   logic signed [ACC_W-1:0] acc;
   assign prod = sample * gain;
   assign sum = acc + ACC_W'(prod);
   always_ff @(posedge clk or negedge rst)
      if (!rst) acc <= '0;
      else if (clr) acc <= '0;
      else if (en) acc <= sum;
endmodule

// File: rtl/eq_band_mixer.sv
// eq_band_mixer: weighted sum of NUM_BANDS band samples using a shadowed gain bank
// Ports: clk, rst (async active-low), ena (global enable), band_in (packed bands, band 0 in LSBs),
//        in_valid/in_ready (frame handshake), gain_we/gain_addr/gain_data (live gain writes),
//        y_out (mixed sample), out_valid (one-cycle result strobe)
// Build option: define EQ_MIX_SATURATE_EN to clamp the result instead of wrapping it.
module eq_band_mixer
   import eq_pkg::*;
#(
   parameter int N         = 16,
   parameter int NUM_BANDS = 8,
   parameter int GAIN_W    = 8,
   parameter int GAIN_FRAC = 6
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ena,
   input  logic [NUM_BANDS*N*2-1:0]        band_in,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            gain_we,
   input  logic [$clog2(NUM_BANDS)-1:0]    gain_addr,
   input  logic signed [GAIN_W-1:0]        gain_data,
   output logic signed [N*2-1:0]           y_out,
   output logic                            out_valid
);
   localparam int W = N * 2;
   localparam int AW = $clog2(NUM_BANDS);
   localparam int ACC_W = acc_width(N, GAIN_W, NUM_BANDS);
   localparam logic signed [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FRAC));
   state_t state, state_nx;
   logic [AW-1:0] idx;
   logic signed [W-1:0] band_q [NUM_BANDS];
   logic signed [GAIN_W-1:0] gain_live [NUM_BANDS];
   logic signed [GAIN_W-1:0] gain_sh [NUM_BANDS];
   logic signed [ACC_W-1:0] sum, shifted;
   logic signed [W-1:0] narrowed;
   logic accept, mac_en, last, gain_hit;
   assign accept = in_ready && in_valid;
   assign mac_en = ena && state == S_ACC;
   assign last = idx == AW'(NUM_BANDS - 1);
   assign gain_hit = gain_we && (int'(gain_addr) < NUM_BANDS);
   always_comb begin
      state_nx = state;
      in_ready = state == S_IDLE && ena;
      out_valid = state == S_OUT;
      if (ena)
         case (state)
            S_IDLE:  state_nx = in_valid ? S_ACC : S_IDLE;
            S_ACC:   state_nx = last ? S_OUT : S_ACC;
            S_OUT:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= S_IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst)
      if (!rst) idx <= '0;
      else if (accept) idx <= '0;
      else if (mac_en) idx <= last ? '0 : idx + 1'b1;
   always_ff @(posedge clk)
      if (accept)
         for (int i = 0; i < NUM_BANDS; i++) band_q[i] <= band_in[i*W +: W];
   // A write landing on the accept edge must reach the shadow bank directly.
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         for (int i = 0; i < NUM_BANDS; i++) begin
            gain_live[i] <= UNITY;
            gain_sh[i] <= UNITY;
         end
      else
         for (int i = 0; i < NUM_BANDS; i++) begin
            if (gain_hit && gain_addr == AW'(i)) gain_live[i] <= gain_data;
            if (accept) gain_sh[i] <= (gain_hit && gain_addr == AW'(i)) ? gain_data : gain_live[i];
         end
   eq_mac #(.N(N), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_mac (
      .clk(clk),
      .rst(rst),
      .clr(accept),
      .en(mac_en),
      .sample(band_q[idx]),
      .gain(gain_sh[idx]),
      .sum(sum)
   );
   assign shifted = sum >>> GAIN_FRAC;
`ifdef EQ_MIX_SATURATE_EN
   // In range only when every bit above the output sign bit matches it.
   assign narrowed = (&shifted[ACC_W-1:W-1] || ~|shifted[ACC_W-1:W-1]) ? shifted[W-1:0]
                   : shifted[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
   assign narrowed = W'(shifted);
`endif
   // The final MAC result is captured on the edge entering OUT so y_out is valid with out_valid.
   always_ff @(posedge clk or negedge rst)
      if (!rst) y_out <= '0;
      else if (mac_en && last) y_out <= narrowed;
endmodule
